// File: rtl/cabac_bin_encoder.sv
// CABAC binary arithmetic encoder: context/bypass bins in, arithmetic-coded bytes out.
// Optional macro BYPASS2_EN: a bypass beat with n_bin=1 encodes two bins in one cycle.
module cabac_bin_encoder #(
  parameter int BUF_CNT_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bin_valid,
  output logic       bin_ready,
  input  logic [1:0] bin_val,
  input  logic       bypass,
  input  logic       n_bin,
  input  logic [7:0] pState_in,
  input  logic       flush,
  output logic       flush_done,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       overflow
);

  typedef enum logic [2:0] {IDLE, EMIT, FL_CARRY, FL_EMIT, FL_TAIL, DONE} state_t;
  localparam logic [BUF_CNT_W-1:0] BUF_ONE = 1;

  state_t state, state_nxt;
  logic [31:0] low;
  logic [8:0]  range;
  logic [5:0]  bits_left;
  logic [BUF_CNT_W-1:0] num_buf, rep_cnt;
  logic [7:0]  buf_byte, rep_byte;

  function automatic logic [7:0] lps_calc(input logic [7:0] pst, input logic [3:0] rng_hi);
    logic [4:0] q5;
    logic [8:0] prod;
    q5   = pst[7] ? ~pst[6:2] : pst[6:2];
    prod = {4'd0, q5} * {5'd0, rng_hi};
    return 8'(prod >> 1) + 8'd4;
  endfunction

  // n = 8 - floor(log2(lps)); lps is never below 4
  function automatic logic [2:0] renorm_shift(input logic [7:0] lps);
    casez (lps)
      8'b1???????: return 3'd1;
      8'b01??????: return 3'd2;
      8'b001?????: return 3'd3;
      8'b0001????: return 3'd4;
      8'b00001???: return 3'd5;
      default:     return 3'd6;
    endcase
  endfunction

  logic [31:0] low_b, low_w, lead, r32, tv;
  logic [8:0]  range_b, rng_m;
  logic [5:0]  bl_b, bl_w, k;
  logic [7:0]  lps, bb_w, q_first, q_rep;
  logic [2:0]  sh;
  logic [BUF_CNT_W-1:0] nb_w, q_cnt;
  logic        queue, ovf_set, fl_carry, tail_two;
  logic [15:0] tail16;

  // bin arithmetic followed by writeOut, all within the accepting cycle
  always_comb begin
    r32     = {23'd0, range};
    lps     = lps_calc(pState_in, range[8:5]);
    rng_m   = range - {1'b0, lps};
    sh      = renorm_shift(lps);
    low_b   = low;
    range_b = range;
    bl_b    = bits_left;
    if (bypass) begin
      low_b = (low << 1) + (bin_val[0] ? r32 : 32'd0);
      bl_b  = bits_left - 6'd1;
`ifdef BYPASS2_EN
      if (n_bin) begin
        low_b = (low << 2) + (bin_val[1] ? (r32 << 1) : 32'd0) + (bin_val[0] ? r32 : 32'd0);
        bl_b  = bits_left - 6'd2;
      end
`endif
    end else if (bin_val[0] != pState_in[7]) begin
      low_b   = (low + {23'd0, rng_m}) << sh;
      range_b = {1'b0, lps} << sh;
      bl_b    = bits_left - {3'd0, sh};
    end else if (rng_m < 9'd256) begin
      low_b   = low << 1;
      range_b = rng_m << 1;
      bl_b    = bits_left - 6'd1;
    end else begin
      range_b = rng_m;
    end

    lead    = low_b >> (6'd24 - bl_b);
    low_w   = low_b;
    bl_w    = bl_b;
    nb_w    = num_buf;
    bb_w    = buf_byte;
    ovf_set = 1'b0;
    queue   = 1'b0;
    q_first = buf_byte + {7'd0, lead[8]};
    q_rep   = lead[8] ? 8'h00 : 8'hFF;
    q_cnt   = num_buf - BUF_ONE;
    if (bl_b < 6'd12) begin
      bl_w  = bl_b + 6'd8;
      low_w = low_b & (32'hFFFF_FFFF >> bl_w);
      if (lead == 32'h0000_00FF) begin
        if (&num_buf) ovf_set = 1'b1;
        else          nb_w = num_buf + BUF_ONE;
      end else begin
        queue = (num_buf != '0);
        bb_w  = lead[7:0];
        nb_w  = BUF_ONE;
      end
    end

    fl_carry = (low >> (6'd32 - bits_left)) != 32'd0;
    k        = 6'd24 - bits_left;
    tv       = (((low >> 8) & ((32'd1 << k) - 32'd1)) << 1) | 32'd1;
    tail16   = 16'(tv << (6'd15 - k));
    tail_two = (k >= 6'd8);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    bin_ready  = 1'b0;
    flush_done = 1'b0;
    data_valid = 1'b0;
    case (state)
      IDLE: begin
        bin_ready = reset;
        if (flush)                  state_nxt = FL_CARRY;
        else if (bin_valid && queue) state_nxt = EMIT;
      end
      EMIT: begin
        data_valid = 1'b1;
        if (data_ready && rep_cnt == '0) state_nxt = IDLE;
      end
      FL_CARRY: state_nxt = (fl_carry || num_buf != '0) ? FL_EMIT : FL_TAIL;
      FL_EMIT: begin
        data_valid = 1'b1;
        if (data_ready && rep_cnt == '0) state_nxt = FL_TAIL;
      end
      FL_TAIL: begin
        data_valid = 1'b1;
        if (data_ready && rep_cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        flush_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      low <= '0; range <= 9'd510; bits_left <= 6'd23;
      num_buf <= '0; buf_byte <= 8'hFF; overflow <= 1'b0;
      data <= '0; rep_byte <= '0; rep_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (!flush && bin_valid) begin
          low <= low_w; range <= range_b; bits_left <= bl_w;
          num_buf <= nb_w; buf_byte <= bb_w;
          if (ovf_set) overflow <= 1'b1;
          if (queue) begin
            data <= q_first; rep_byte <= q_rep; rep_cnt <= q_cnt;
          end
        end
        EMIT, FL_EMIT, FL_TAIL: if (data_ready) begin
          if (rep_cnt != '0) begin
            data <= rep_byte; rep_cnt <= rep_cnt - BUF_ONE;
          end else if (state == FL_EMIT) begin
            data <= tail16[15:8]; rep_byte <= tail16[7:0]; rep_cnt <= tail_two ? BUF_ONE : '0;
          end
        end
        FL_CARRY: begin
          if (fl_carry) begin
            data <= buf_byte + 8'd1; rep_byte <= 8'h00;
            rep_cnt <= (num_buf == '0) ? '0 : num_buf - BUF_ONE;
            low <= low - (32'd1 << (6'd32 - bits_left));
          end else if (num_buf != '0) begin
            data <= buf_byte; rep_byte <= 8'hFF; rep_cnt <= num_buf - BUF_ONE;
          end else begin
            data <= tail16[15:8]; rep_byte <= tail16[7:0]; rep_cnt <= tail_two ? BUF_ONE : '0;
          end
        end
        DONE: begin
          low <= '0; range <= 9'd510; bits_left <= 6'd23;
          num_buf <= '0; buf_byte <= 8'hFF;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cabac_bin_encoder.sv
// Directed bench for cabac_bin_encoder with hand-computed byte streams.
module tb_cabac_bin_encoder;
  logic       clk, reset, bin_valid, bin_ready, bypass, n_bin, flush, flush_done;
  logic [1:0] bin_val;
  logic [7:0] pState_in, data;
  logic       data_valid, data_ready, overflow;

  int tests = 0, fails = 0;
  int br_bad, dv_bad, stable_bad, ready_bad;
  logic done_seen;
  logic [7:0] got[$];

  cabac_bin_encoder #(.BUF_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bin_valid(bin_valid), .bin_ready(bin_ready),
    .bin_val(bin_val), .bypass(bypass), .n_bin(n_bin), .pState_in(pState_in),
    .flush(flush), .flush_done(flush_done), .data(data), .data_valid(data_valid),
    .data_ready(data_ready), .overflow(overflow));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] gb(input int i);
    return (i < got.size()) ? {1'b0, got[i]} : 9'h100;
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 20 && bin_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_run(input int n, input logic byp, input logic [1:0] v,
                          input logic nb, input logic [7:0] ps);
    wait_ready();
    for (int i = 0; i < n; i++) begin
      bin_valid = 1'b1; bypass = byp; bin_val = v; n_bin = nb; pState_in = ps;
      if (bin_ready !== 1'b1) br_bad++;
      if (data_valid !== 1'b0) dv_bad++;
      @(posedge clk); #1;
    end
    bin_valid = 1'b0;
  endtask

  task automatic do_flush();
    wait_ready();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic collect(input int stall, input int max_cyc);
    int waitc;
    logic [7:0] held;
    got.delete(); done_seen = 1'b0; stable_bad = 0; ready_bad = 0; waitc = 0; held = '0;
    for (int c = 0; c < max_cyc; c++) begin
      if (flush_done === 1'b1) done_seen = 1'b1;
      else if (data_valid === 1'b1) begin
        if (bin_ready !== 1'b0) ready_bad++;
        if (waitc == 0) held = data;
        else if (data !== held) stable_bad++;
        if (waitc < stall) begin data_ready = 1'b0; waitc++; end
        else begin data_ready = 1'b1; got.push_back(data); waitc = 0; end
      end else data_ready = 1'b0;
      if (done_seen) break;
      @(posedge clk); #1;
      data_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; #1 reset = 1'b0;
    @(posedge clk); #1;
    tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL rst_data_valid: got %b want 0", data_valid); end
    tests++; if (flush_done !== 1'b0) begin fails++; $display("FAIL rst_flush_done: got %b want 0", flush_done); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    tests++; if (data !== 8'h00) begin fails++; $display("FAIL rst_data: got %h want 00", data); end
    tests++; if (bin_ready !== 1'b0) begin fails++; $display("FAIL rst_bin_ready_in_reset: got %b want 0", bin_ready); end
    reset = 1'b1;
    @(posedge clk); #1;
    tests++; if (bin_ready !== 1'b1) begin fails++; $display("FAIL rst_bin_ready_release: got %b want 1", bin_ready); end
  endtask

  task automatic test_bypass8();
    br_bad = 0; dv_bad = 0;
    send_run(8, 1'b1, 2'b01, 1'b0, 8'h00);
    do_flush();
    collect(0, 100);
    tests++; if (br_bad !== 0) begin fails++; $display("FAIL b8_bin_ready: %0d stalls want 0", br_bad); end
    tests++; if (dv_bad !== 0) begin fails++; $display("FAIL b8_early_valid: %0d cycles want 0", dv_bad); end
    tests++; if (got.size() !== 2) begin fails++; $display("FAIL b8_count: got %0d want 2", got.size()); end
    tests++; if (gb(0) !== 9'h0FE) begin fails++; $display("FAIL b8_byte0: got %h want 0fe", gb(0)); end
    tests++; if (gb(1) !== 9'h040) begin fails++; $display("FAIL b8_byte1: got %h want 040", gb(1)); end
    tests++; if (done_seen !== 1'b1) begin fails++; $display("FAIL b8_flush_done: got %b want 1", done_seen); end
  endtask

  task automatic test_bypass12(input int stall);
    br_bad = 0;
    send_run(12, 1'b1, 2'b01, 1'b0, 8'h00);
    collect(0, 5);
    tests++; if (got.size() !== 0) begin fails++; $display("FAIL b12_pre_flush: got %0d bytes want 0", got.size()); end
    do_flush();
    collect(stall, 200);
    tests++; if (br_bad !== 0) begin fails++; $display("FAIL b12_bin_ready: %0d stalls want 0", br_bad); end
    tests++; if (got.size() !== 2) begin fails++; $display("FAIL b12_count(stall %0d): got %0d want 2", stall, got.size()); end
    tests++; if (gb(0) !== 9'h0FE) begin fails++; $display("FAIL b12_byte0(stall %0d): got %h want 0fe", stall, gb(0)); end
    tests++; if (gb(1) !== 9'h0F4) begin fails++; $display("FAIL b12_byte1(stall %0d): got %h want 0f4", stall, gb(1)); end
    tests++; if (done_seen !== 1'b1) begin fails++; $display("FAIL b12_flush_done: got %b want 1", done_seen); end
    tests++; if (stable_bad !== 0) begin fails++; $display("FAIL b12_data_stable: %0d changes want 0", stable_bad); end
    tests++; if (ready_bad !== 0) begin fails++; $display("FAIL b12_bin_ready_busy: %0d cycles want 0", ready_bad); end
  endtask

  task automatic test_context_lps();
    send_run(1, 1'b0, 2'b01, 1'b0, 8'h00);
    do_flush();
    collect(0, 100);
    tests++; if (got.size() !== 1) begin fails++; $display("FAIL ctx_count: got %0d want 1", got.size()); end
    tests++; if (gb(0) !== 9'h0FD) begin fails++; $display("FAIL ctx_byte0: got %h want 0fd", gb(0)); end
    tests++; if (done_seen !== 1'b1) begin fails++; $display("FAIL ctx_flush_done: got %b want 1", done_seen); end
  endtask

  task automatic test_emit();
    send_run(12, 1'b1, 2'b01, 1'b0, 8'h00);
    send_run(8, 1'b1, 2'b00, 1'b0, 8'h00);
    tests++; if (data_valid !== 1'b1) begin fails++; $display("FAIL emit_latency: got %b want 1", data_valid); end
    tests++; if (data !== 8'hFE) begin fails++; $display("FAIL emit_byte: got %h want fe", data); end
    tests++; if (bin_ready !== 1'b0) begin fails++; $display("FAIL emit_bin_ready: got %b want 0", bin_ready); end
    collect(0, 6);
    tests++; if (got.size() !== 1 || gb(0) !== 9'h0FE) begin fails++; $display("FAIL emit_stream: got %0d bytes first %h want 1 x 0fe", got.size(), gb(0)); end
    do_flush();
    collect(0, 100);
    tests++; if (got.size() !== 2) begin fails++; $display("FAIL emit_flush_count: got %0d want 2", got.size()); end
    tests++; if (gb(0) !== 9'h0F0) begin fails++; $display("FAIL emit_flush_byte0: got %h want 0f0", gb(0)); end
    tests++; if (gb(1) !== 9'h014) begin fails++; $display("FAIL emit_flush_byte1: got %h want 014", gb(1)); end
  endtask

  task automatic test_reset_tail();
    logic seen;
    send_run(8, 1'b1, 2'b01, 1'b0, 8'h00);
    do_flush();
    seen = 1'b0; data_ready = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (data_valid === 1'b1) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL rt_reach_tail: got %b want 1", seen); end
    #2 reset = 1'b0;
    #1;
    tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL rt_async_drop: got %b want 0", data_valid); end
    tests++; if (flush_done !== 1'b0) begin fails++; $display("FAIL rt_flush_done: got %b want 0", flush_done); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    send_run(8, 1'b1, 2'b01, 1'b0, 8'h00);
    do_flush();
    collect(0, 100);
    tests++; if (got.size() !== 2) begin fails++; $display("FAIL rt_count: got %0d want 2", got.size()); end
    tests++; if (gb(0) !== 9'h0FE) begin fails++; $display("FAIL rt_byte0: got %h want 0fe", gb(0)); end
    tests++; if (gb(1) !== 9'h040) begin fails++; $display("FAIL rt_byte1: got %h want 040", gb(1)); end
    tests++; if (done_seen !== 1'b1) begin fails++; $display("FAIL rt_flush_done_after: got %b want 1", done_seen); end
  endtask

  task automatic test_nbin();
    send_run(4, 1'b1, 2'b11, 1'b1, 8'h00);
    do_flush();
    collect(0, 100);
`ifdef BYPASS2_EN
    tests++; if (got.size() !== 2) begin fails++; $display("FAIL nbin2_count: got %0d want 2", got.size()); end
    tests++; if (gb(0) !== 9'h0FE) begin fails++; $display("FAIL nbin2_byte0: got %h want 0fe", gb(0)); end
    tests++; if (gb(1) !== 9'h040) begin fails++; $display("FAIL nbin2_byte1: got %h want 040", gb(1)); end
`else
    tests++; if (got.size() !== 1) begin fails++; $display("FAIL nbin1_count: got %0d want 1", got.size()); end
    tests++; if (gb(0) !== 9'h0EC) begin fails++; $display("FAIL nbin1_byte0: got %h want 0ec", gb(0)); end
`endif
    tests++; if (done_seen !== 1'b1) begin fails++; $display("FAIL nbin_flush_done: got %b want 1", done_seen); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL nbin_overflow: got %b want 0", overflow); end
  endtask

  initial begin
    bin_valid = 1'b0; bypass = 1'b0; n_bin = 1'b0; bin_val = 2'b00;
    pState_in = 8'h00; flush = 1'b0; data_ready = 1'b0;
    test_reset();
    test_bypass8();
    test_bypass12(0);
    test_context_lps();
    test_bypass12(5);
    test_emit();
    test_reset_tail();
    test_nbin();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cabac_bin_encoder.md
Name: cabac_bin_encoder

Overview:
VVC CABAC binary arithmetic encoder. It is the write side of the byte stream our Decoder consumes.
- Accepts context-coded or bypass bins, using the same pState/bypass/n_bin encoding the Decoder takes.
- Emits the arithmetic-coded byte stream over a valid/ready byte interface.
- Used to generate golden bitstreams in-sim and as the producer end in encode→decode loopback benches.

Parameters:
BUF_CNT_W, 16, width of the outstanding-0xFF-byte counter (numBuffered).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
bin_valid  in  1  bin request valid.
bin_ready  out  1  encoder can accept a bin or flush this cycle.
bin_val  in  2  bin value(s); bin_val[0] is used for a single bin.
bypass  in  1  1 = bypass (equiprobable) bin, 0 = context bin.
n_bin  in  1  bypass-only: 1 = two bins this beat (see BYPASS2_EN).
pState_in  in  8  context state: [7] = MPS, [6:0] = probability.
flush  in  1  terminate slice: drain all state, append stop bit, pad.
flush_done  out  1  one-cycle pulse after the last flush byte is accepted.
data  out  8  output byte.
data_valid  out  1  byte valid.
data_ready  in  1  sink accepts the byte.
overflow  out  1  sticky: numBuffered saturated; cleared only by reset.

Behaviour:
- Reset (async, reset=0) forces:
  - low=0, range=510, bitsLeft=23, numBuffered=0, bufferedByte=0xFF.
  - state=IDLE; all outputs 0 except bin_ready=1 after release.
- bin_ready=1 only in IDLE.
- A bin is consumed on bin_valid & bin_ready & ~flush. If flush & bin_ready, flush wins and the bin is not consumed.
- Context bin: mps=pState_in[7]; q5 = mps ? ~pState_in[6:2] : pState_in[6:2].
  - LPS = ((q5*range[8:5])>>1)+4, always in 4..236.
  - range -= LPS.
  - If bin_val[0]≠mps: n = 8-floor(log2 LPS); low=(low+range)<<n; range=LPS<<n; bitsLeft-=n.
  - Else, if range<256: low<<=1; range<<=1; bitsLeft-=1.
- Bypass bin b: low=(low<<1)+(b?range:0); bitsLeft-=1.
- low is 32 bits; all arithmetic is unsigned and truncated to 32 bits.
- writeOut is evaluated in the same cycle as a bin when the post-bin bitsLeft<12:
  - lead=low>>(24-bitsLeft); bitsLeft+=8; low&=0xFFFFFFFF>>bitsLeft.
  - lead==0xFF: numBuffered++. Saturate at all-ones and set overflow.
  - Else if numBuffered>0:
    - carry=lead[8]; queue bufferedByte+carry, then (numBuffered-1) copies of (0xFF+carry)&0xFF.
    - Then bufferedByte=lead[7:0] and numBuffered=1.
  - Else: bufferedByte=lead[7:0]; numBuffered=1.
- If writeOut queues bytes, go IDLE→EMIT. Otherwise stay in IDLE; back-to-back bins are accepted at one per cycle.
- EMIT:
  - One byte is presented per cycle.
  - data/data_valid are held stable while data_ready=0.
  - Return to IDLE the cycle after the last handshake.
- Flush sequence FL_CARRY→FL_EMIT→FL_TAIL→DONE:
  - FL_CARRY, carry=(low>>(32-bitsLeft))≠0:
    - Carry case: emit bufferedByte+1, then (numBuffered-1)×0x00; low-=1<<(32-bitsLeft).
    - No carry: if numBuffered>0, emit bufferedByte, then (numBuffered-1)×0xFF.
  - FL_TAIL: emit the (24-bitsLeft) LSBs of low>>8 MSB-first, then a single 1 stop bit, then zero-pad to a byte boundary. This is at most 2 bytes.
  - DONE: flush_done=1 for one cycle; reinitialize registers to reset values; go to IDLE.
- Latency: a bin consumed in cycle t updates state visibly by t+1. The first queued byte has data_valid at t+1.
- Reset mid-EMIT or mid-flush aborts immediately: pending bytes are dropped and data_valid falls asynchronously.

Optional Feature:
BYPASS2_EN
- Defined: a bypass beat with n_bin=1 encodes bin_val[1] then bin_val[0] in one cycle (bitsLeft-=2; writeOut once).
- Undefined: n_bin is ignored; every beat encodes bin_val[0] only.
- n_bin is ignored for context bins in both builds.

Test Plan:
- Reset, 8 bypass bins of 1, flush → bytes 0xFE, 0x40, then flush_done; no data_valid before the flush.
- Reset, 12 bypass bins of 1 → no output (bufferedByte=0xFE internally); flush → 0xFE, 0xF4.
- Reset, context bin pState_in=0x00, bin_val=1 (LPS), flush → single byte 0xFD.
- Repeat the second scenario with data_ready held 0 for 5 cycles on each byte → data stable, bin_ready=0, same byte sequence.
- Assert reset during FL_TAIL → data_valid=0 immediately; after release a fresh 8×bypass-1+flush again yields 0xFE, 0x40.
- BYPASS2_EN: 4 beats of n_bin=1, bin_val=2'b11, then flush → 0xFE, 0x40, identical to the first scenario.
